// File: rtl/ga_vram_arbiter.sv
// ga_vram_arbiter: time-slot arbiter that shares one fixed-latency synchronous
// RAM port between gate-array video fetch, the Z80 CPU and an aux (loader/DMA)
// port. Each 16-tick microsecond holds four 4-tick windows:
//   W0 video even byte, W1 video odd byte, W2 CPU (aux if CPU idle), W3 aux.
// Optional build macro GA_ARB_CPU_W3_EN: CPU may also take W3 when aux is idle.
module ga_vram_arbiter #(
  parameter int LATENCY = 2,   // cen_16 ticks from issue to read data, 1..3
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen_16,
  input  logic          phase_sync,
  input  logic [AW-1:0] vid_addr,
  output logic [15:0]   vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [7:0]    aux_din,
  output logic [7:0]    aux_dout,
  output logic          aux_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout
);

  localparam logic [1:0] TAG_VID0 = 2'd0;
  localparam logic [1:0] TAG_VID1 = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;
  localparam logic [1:0] TAG_AUX  = 2'd3;

  logic [3:0]         sl, sl_nxt;
  logic               resync, win_start, capture;
  // One bit per tick of flight; an access issued at a window start always
  // retires before the next window opens, so a single tag describes it.
  logic [LATENCY-1:0] vld_pipe;
  logic [1:0]         inf_tag;
  logic               inf_we;
  logic [AW-1:1]      vid_hi;
  logic [7:0]         vid_lo;

  logic               iss_vld, iss_we;
  logic [1:0]         iss_tag;
  logic [AW-1:0]      iss_addr;
  logic [7:0]         iss_din;

  // Video addresses are word addresses; the byte select comes from the window.
  logic unused_vid_lsb;
  assign unused_vid_lsb = vid_addr[0];

  // Next slot, resync detection and capture qualification for this tick
  always_comb begin
    sl_nxt    = phase_sync ? 4'd0 : sl + 4'd1;
    resync    = phase_sync && (sl != 4'd15);
    win_start = (sl_nxt[1:0] == 2'b00);
    // A resync on the capture tick itself still cancels the access.
    capture   = vld_pipe[LATENCY-1] && !resync;
  end

  // Window owner selection for the tick that opens a window
  always_comb begin
    iss_vld  = 1'b0;
    iss_tag  = TAG_VID0;
    iss_we   = 1'b0;
    iss_addr = '0;
    iss_din  = '0;
    if (win_start) begin
      case (sl_nxt[3:2])
        2'd0: begin
          iss_vld  = 1'b1;
          iss_tag  = TAG_VID0;
          iss_addr = {vid_addr[AW-1:1], 1'b0};
        end
        2'd1: begin
          iss_vld  = 1'b1;
          iss_tag  = TAG_VID1;
          iss_addr = {vid_hi, 1'b1};
        end
        2'd2: begin
          if (cpu_req) begin
            iss_vld = 1'b1; iss_tag = TAG_CPU; iss_we = cpu_we;
            iss_addr = cpu_addr; iss_din = cpu_din;
          end else if (aux_req) begin
            iss_vld = 1'b1; iss_tag = TAG_AUX; iss_we = aux_we;
            iss_addr = aux_addr; iss_din = aux_din;
          end
        end
        default: begin
          if (aux_req) begin
            iss_vld = 1'b1; iss_tag = TAG_AUX; iss_we = aux_we;
            iss_addr = aux_addr; iss_din = aux_din;
          end
`ifdef GA_ARB_CPU_W3_EN
          else if (cpu_req) begin
            iss_vld = 1'b1; iss_tag = TAG_CPU; iss_we = cpu_we;
            iss_addr = cpu_addr; iss_din = cpu_din;
          end
`endif
        end
      endcase
    end
  end

  // Slot counter and in-flight tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      sl       <= '0;
      vld_pipe <= '0;
      inf_tag  <= TAG_VID0;
      inf_we   <= 1'b0;
      vid_hi   <= '0;
    end else if (cen_16) begin
      sl       <= sl_nxt;
      vld_pipe <= (resync ? '0 : (vld_pipe << 1)) | LATENCY'(iss_vld);
      if (iss_vld) begin
        inf_tag <= iss_tag;
        inf_we  <= iss_we;
      end
      if (iss_vld && iss_tag == TAG_VID0) vid_hi <= vid_addr[AW-1:1];
    end
  end

  // RAM strobes: asserted for exactly the tick period following an issue
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
    end else if (cen_16) begin
      mem_rd  <= iss_vld && !iss_we;
      mem_we  <= iss_vld && iss_we;
      mem_din <= (iss_vld && iss_we) ? iss_din : 8'h00;
      if (iss_vld) mem_addr <= iss_addr;
    end
  end

  // Read-data capture and one-clk completion pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_lo    <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_dout  <= '0;
      cpu_ack   <= 1'b0;
      aux_dout  <= '0;
      aux_ack   <= 1'b0;
    end else begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      aux_ack   <= 1'b0;
      if (cen_16 && capture) begin
        case (inf_tag)
          TAG_VID0: vid_lo <= mem_dout;
          TAG_VID1: begin
            vid_data  <= {mem_dout, vid_lo};
            vid_valid <= 1'b1;
          end
          TAG_CPU: begin
            if (!inf_we) cpu_dout <= mem_dout;
            cpu_ack <= 1'b1;
          end
          default: begin
            if (!inf_we) aux_dout <= mem_dout;
            aux_ack <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
